// File: rtl/serializador_9bit_if.sv
// Parallel-in / serial-out bus between the byte-level transmit logic and the serializer.
interface serializador_9bit_if;
    logic [7:0] data;   // parallel byte, sampled at frame load
    logic       DK;     // 1 = control/K character, 0 = data
    logic       out;    // registered serial line

    // Byte source side: drives the frame, observes the line
    modport master (output data, output DK, input out);
    // Serializer side
    modport slave  (input data, input DK, output out);
endinterface

// File: rtl/serializador_9bit.sv
// 9-bit parallel-to-serial converter: frame = {DK, data[7:0]}, shifted MSB first,
// back-to-back with no gap bits. enb low is an asynchronous abort/reset.
module serializador_9bit (
    input  logic                clk,
    input  logic                enb,
    serializador_9bit_if.slave  bus
);
    localparam int unsigned FRAME_W  = 9;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned LAST_BIT = FRAME_W - 1;

    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               out_q,   out_d;
    logic               load_c;
    logic [CNT_W-1:0]   bit_idx_c;

    // State registers; enb low clears everything immediately
    always_ff @(posedge clk or negedge enb) begin
        if (!enb) begin
            frame_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // Next-state: load on cnt 0 (or any unreachable value), otherwise shift the next bit
    always_comb begin
        frame_d   = frame_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        load_c    = (cnt_q == '0) || (cnt_q > CNT_W'(LAST_BIT));
        bit_idx_c = CNT_W'(LAST_BIT) - cnt_q;

        if (load_c) begin
            frame_d = {bus.DK, bus.data};
            out_d   = bus.DK;
            cnt_d   = CNT_W'(1);
        end else begin
            out_d = frame_q[bit_idx_c];
            cnt_d = (cnt_q == CNT_W'(LAST_BIT)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_serializador_9bit.sv
// Scoreboard bench: stimulus pushes expected serial bits, a monitor pops and compares.
module tb_serializador_9bit;
    logic clk;
    logic enb;
    int   checks;
    int   errors;
    logic exp_q[$];

    serializador_9bit_if bus ();

    serializador_9bit dut (
        .clk (clk),
        .enb (enb),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push nine expected bits, MSB first
    task automatic push_bits(input logic [8:0] bits);
        for (int i = 8; i >= 0; i--) exp_q.push_back(bits[i]);
    endtask

    // Present a frame before its load edge and let it shift out completely
    task automatic send_frame(input logic dk, input logic [7:0] d, input logic [8:0] bits);
        bus.DK   = dk;
        bus.data = d;
        push_bits(bits);
        repeat (9) @(negedge clk);
    endtask

    // Monitor: 3 time units after each rising edge, compare the line
    initial begin
        logic enb_at_edge;
        logic want;
        forever begin
            @(posedge clk);
            enb_at_edge = enb;
            #3;
            if (enb_at_edge && enb) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL underrun: out=%0b with no expected bit queued at %0t", bus.out, $time);
                end else begin
                    want = exp_q.pop_front();
                    if (bus.out !== want) begin
                        errors++;
                        $display("FAIL serial_bit: got %0b want %0b at %0t", bus.out, want, $time);
                    end
                end
            end else begin
                checks++;
                if (bus.out !== 1'b0) begin
                    errors++;
                    $display("FAIL out_in_reset: got %0b want 0 at %0t", bus.out, $time);
                end
            end
        end
    end

    initial begin
        logic       rdk;
        logic [7:0] rd;
        checks   = 0;
        errors   = 0;
        enb      = 1'b0;
        bus.DK   = 1'b1;
        bus.data = 8'hFF;

        // Reset held for 3 clocks with all-ones inputs
        repeat (3) @(negedge clk);

        // Single frame DK=1 A5 -> 1,1,0,1,0,0,1,0,1
        enb = 1'b1;
        send_frame(1'b1, 8'hA5, 9'b110100101);

        // Back-to-back frames, no gap
        send_frame(1'b0, 8'h3C, 9'b000111100);
        send_frame(1'b1, 8'h81, 9'b110000001);

        // Mid-frame input change must not disturb the frame in flight
        bus.DK   = 1'b0;
        bus.data = 8'h00;
        push_bits(9'b000000000);
        @(negedge clk);
        bus.DK   = 1'b1;
        bus.data = 8'hFF;
        repeat (8) @(negedge clk);
        send_frame(1'b1, 8'hFF, 9'b111111111);

        // Abort after 4 bits of DK=1 F0 (fourth bit on the line is a 1)
        bus.DK   = 1'b1;
        bus.data = 8'hF0;
        push_bits(9'b111110000);
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (bus.out !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort_bit: got %0b want 1", bus.out);
        end
        enb = 1'b0;
        #1;
        checks++;
        if (bus.out !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: got %0b want 0", bus.out);
        end
        exp_q.delete();
        bus.DK   = 1'b0;
        bus.data = 8'h5A;
        repeat (2) @(negedge clk);

        // Restart: fresh full frame DK=0 5A -> 0,0,1,0,1,1,0,1,0
        enb = 1'b1;
        send_frame(1'b0, 8'h5A, 9'b001011010);

        // Long run of random frames against the DK-then-MSB-first order
        for (int n = 0; n < 256; n++) begin
            rdk = 1'($urandom_range(0, 1));
            rd  = 8'($urandom_range(0, 255));
            send_frame(rdk, rd, {rdk, rd});
        end

        // Stop before the next load edge and confirm every bit was seen
        enb = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_bits: got %0d queued want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
